// File: rtl/cla_sub_seq_if.sv
// Handshake and operand/result bundle for the sequential CLA subtractor.
// The slave side belongs to the subtractor, the master side to its requester.
interface cla_sub_seq_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;
    logic             zero;

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout, ovf, zero
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout, ovf, zero
    );
endinterface

// File: rtl/cla_sub_seq.sv
// Sequential WIDTH-bit subtractor: diff = a - b - bin, one 4-bit carry-lookahead
// slice per clock, LSB nibble first, behind a start/busy/done handshake.
module cla_sub_seq #(
    parameter int WIDTH = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    cla_sub_seq_if.slave  bus
);
    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CW-1:0] LAST = CW'(NIB - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_carry;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;
    logic             r_ovf;
    logic             r_zero;

    logic [CW+1:0]    w_base;
    logic [3:0]       w_x;
    logic [3:0]       w_y;
    logic [3:0]       w_g;
    logic [3:0]       w_p;
    logic [3:0]       w_s;
    logic [4:0]       w_c;
    logic [WIDTH-1:0] w_res_next;

    // Current slice: minuend nibble plus inverted subtrahend nibble.
    assign w_base = {r_cnt, 2'b00};
    assign w_x    = r_a[w_base +: 4];
    assign w_y    = ~r_b[w_base +: 4];
    assign w_c[0] = r_carry;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_slice
            assign w_g[gi] = w_x[gi] & w_y[gi];
            assign w_p[gi] = w_x[gi] ^ w_y[gi];
            assign w_s[gi] = w_p[gi] ^ w_c[gi];
        end
    endgenerate

    // Full lookahead carries, same equations as the adder4 nibble.
    assign w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[0]);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[0]);

    always_comb begin
        w_res_next = r_res;
        w_res_next[w_base +: 4] = w_s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_diff  <= '0;
            r_bout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        // Subtract as a + ~b + ~bin: the borrow-in enters inverted.
                        r_a     <= bus.a;
                        r_b     <= bus.b;
                        r_carry <= ~bus.bin;
                        r_res   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    r_res   <= w_res_next;
                    r_carry <= w_c[4];
                    if (r_cnt == LAST) begin
                        r_diff  <= w_res_next;
                        r_bout  <= ~w_c[4];
                        r_ovf   <= (r_a[WIDTH-1] != r_b[WIDTH-1]) &&
                                   (w_res_next[WIDTH-1] != r_a[WIDTH-1]);
                        r_zero  <= (w_res_next == '0);
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.diff = r_diff;
    assign bus.bout = r_bout;
    assign bus.ovf  = r_ovf;
    assign bus.zero = r_zero;
endmodule

// File: tb/tb_cla_sub_seq.sv
// Testbench for cla_sub_seq (WIDTH=16): directed vector table, handshake and
// reset corner cases, then random operands against an arithmetic reference.
module tb_cla_sub_seq;
    localparam int W = 16;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        bin;
        logic [15:0] diff;
        logic        bout;
        logic        ovf;
        logic        zero;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;
    int   cyc;
    int   both_high;

    cla_sub_seq_if #(.WIDTH(W)) sif ();

    cla_sub_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && sif.busy && sif.done) both_high <= both_high + 1;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
        end
    endtask

    // Issue one operation and wait for done; hold keeps start high with
    // scrambled operands until done is seen.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic bin,
                          input bit hold, output int lat);
        sif.start = 1'b1;
        sif.a     = a;
        sif.b     = b;
        sif.bin   = bin;
        @(posedge clk);
        #1;
        if (!hold) sif.start = 1'b0;
        lat = 0;
        while (lat < 20) begin
            if (hold) begin
                sif.a   = 16'($urandom);
                sif.b   = 16'($urandom);
                sif.bin = 1'($urandom);
            end
            @(posedge clk);
            #1;
            lat++;
            if (sif.done) break;
        end
        sif.start = 1'b0;
    endtask

    task automatic check_result(input string tag, input vec_t v, input int lat);
        check({tag, ".lat"},  32'(lat),      32'd4);
        check({tag, ".done"}, 32'(sif.done), 32'd1);
        check({tag, ".diff"}, 32'(sif.diff), 32'(v.diff));
        check({tag, ".bout"}, 32'(sif.bout), 32'(v.bout));
        check({tag, ".ovf"},  32'(sif.ovf),  32'(v.ovf));
        check({tag, ".zero"}, 32'(sif.zero), 32'(v.zero));
    endtask

    // Reference computed with plain integer arithmetic.
    function automatic vec_t model(input logic [15:0] a, input logic [15:0] b, input logic bin);
        vec_t        v;
        logic [16:0] wide;
        int          sd;
        wide   = {1'b0, a} - {1'b0, b} - {16'd0, bin};
        sd     = int'($signed(a)) - int'($signed(b)) - int'(bin);
        v.a    = a;
        v.b    = b;
        v.bin  = bin;
        v.diff = wide[15:0];
        v.bout = wide[16];
        v.ovf  = (sd > 32767) || (sd < -32768);
        v.zero = (wide[15:0] == 16'd0);
        return v;
    endfunction

    vec_t vecs[7];

    initial begin
        int   lat;
        int   t_first;
        int   seen;
        vec_t v;

        vecs[0] = '{16'h0008, 16'h0008, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{16'h0005, 16'h0001, 1'b1, 16'h0003, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};

        n_cmp = 0; n_bad = 0; cyc = 0; both_high = 0;
        sif.start = 1'b0; sif.a = '0; sif.b = '0; sif.bin = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.busy", 32'(sif.busy), 0);
        check("rst.done", 32'(sif.done), 0);
        check("rst.diff", 32'(sif.diff), 0);
        check("rst.flags", {29'd0, sif.bout, sif.ovf, sif.zero}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].bin, 1'b0, lat);
            $display("vec %0d: %h - %h - %0d -> diff=%h bout=%0d ovf=%0d zero=%0d lat=%0d",
                     i, vecs[i].a, vecs[i].b, vecs[i].bin, sif.diff, sif.bout, sif.ovf, sif.zero, lat);
            check_result($sformatf("vec%0d", i), vecs[i], lat);
            @(posedge clk); #1;
            check("done.pulse", 32'(sif.done), 0);
            check("hold.diff", 32'(sif.diff), 32'(vecs[i].diff));
        end

        // Start held high during RUN with changing operands.
        run_op(16'h1234, 16'h0034, 1'b0, 1'b1, lat);
        $display("hold: diff=%h lat=%0d", sif.diff, lat);
        check_result("holdrun", model(16'h1234, 16'h0034, 1'b0), lat);
        @(posedge clk); #1;
        check("holdrun.idle", 32'(sif.busy), 0);

        // Back-to-back: new start issued in the DONE cycle.
        run_op(16'h0030, 16'h0010, 1'b0, 1'b0, lat);
        t_first = cyc;
        check_result("b2b.first", model(16'h0030, 16'h0010, 1'b0), lat);
        run_op(16'h000F, 16'h0000, 1'b0, 1'b0, lat);
        $display("b2b: diff=%h gap=%0d", sif.diff, cyc - t_first);
        check("b2b.gap", 32'(cyc - t_first), 32'd5);
        check_result("b2b.second", model(16'h000F, 16'h0000, 1'b0), lat);
        @(posedge clk); #1;

        // Asynchronous reset in the second RUN cycle aborts the operation.
        sif.start = 1'b1; sif.a = 16'h4321; sif.b = 16'h0001; sif.bin = 1'b0;
        @(posedge clk); #1;
        sif.start = 1'b0;
        @(posedge clk); #2;
        check("abort.busy_before", 32'(sif.busy), 1);
        rst_n = 1'b0;
        #1;
        check("abort.busy", 32'(sif.busy), 0);
        check("abort.diff", 32'(sif.diff), 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (sif.done || sif.busy) seen++;
        end
        $display("abort: activity cycles after reset=%0d", seen);
        check("abort.no_done", 32'(seen), 0);

        // Random operands.
        for (int k = 0; k < 1000; k++) begin
            v = model(16'($urandom), 16'($urandom), 1'($urandom));
            run_op(v.a, v.b, v.bin, 1'b0, lat);
            $display("rnd %0d: %h - %h - %0d -> diff=%h bout=%0d ovf=%0d zero=%0d",
                     k, v.a, v.b, v.bin, sif.diff, sif.bout, sif.ovf, sif.zero);
            check_result("rnd", v, lat);
            if ((k % 3) == 0) begin
                @(posedge clk); #1;
            end
        end

        check("busy_and_done", 32'(both_high), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
